// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU with funct decode, destination select,
// and a multi-cycle multiply/divide unit with HI/LO that stalls the front end.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset_in,
    input  logic [1:0]      WB_in,
    input  logic [1:0]      M_in,
    input  logic [3:0]      EX_in,
    input  logic [XLEN-1:0] Reg1Data_in,
    input  logic [XLEN-1:0] Reg2Data_in,
    input  logic [XLEN-1:0] Sext_in,
    input  logic [4:0]      Regs_in,
    input  logic [4:0]      Regt_in,
    input  logic [4:0]      Regd_in,
    input  logic            EXMEM_RegWrite,
    input  logic [4:0]      EXMEM_Rd,
    input  logic [XLEN-1:0] EXMEM_Result,
    input  logic            MEMWB_RegWrite,
    input  logic [4:0]      MEMWB_Rd,
    input  logic [XLEN-1:0] MEMWB_Data,
    output logic [1:0]      WB_out,
    output logic [1:0]      M_out,
    output logic [XLEN-1:0] ALUResult_out,
    output logic [XLEN-1:0] WriteData_out,
    output logic [4:0]      RegDst_out,
    output logic            Zero_out,
    output logic            stall_out
);
    // state  | meaning
    // S_IDLE | no mult/div in flight; a muldiv funct stalls and issues
    // S_BUSY | one shift-add / restoring-divide iteration per cycle
    // S_DONE | HI/LO valid, muldiv instruction retires without stall
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam int CW = $clog2(MD_CYCLES + 1);

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_hi, r_lo, r_p_hi, r_p_lo, r_mcand, r_dividend;
    logic              r_is_div, r_neg_q, r_neg_r, r_div0;

    logic [XLEN-1:0]   w_op_a, w_fwd_b, w_op_b, w_result;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_step_hi, w_step_lo;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN:0]     w_add, w_rem_sh, w_rem_sub;
    logic [1:0]        w_alu_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_shamt;
    logic              w_md_funct, w_signed_op, w_sa, w_sb, w_ge, w_stall;

    assign w_alu_op    = EX_in[2:1];
    assign w_funct     = Sext_in[5:0];
    assign w_shamt     = Sext_in[10:6];
    assign w_md_funct  = (w_alu_op == 2'b10) &&
                         (w_funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    assign w_signed_op = !w_funct[0];

    // EX/MEM takes priority over MEM/WB; r0 is never forwarded
    always_comb begin
        w_op_a = Reg1Data_in;
        if (EXMEM_RegWrite && EXMEM_Rd != 5'd0 && EXMEM_Rd == Regs_in)
            w_op_a = EXMEM_Result;
        else if (MEMWB_RegWrite && MEMWB_Rd != 5'd0 && MEMWB_Rd == Regs_in)
            w_op_a = MEMWB_Data;
        w_fwd_b = Reg2Data_in;
        if (EXMEM_RegWrite && EXMEM_Rd != 5'd0 && EXMEM_Rd == Regt_in)
            w_fwd_b = EXMEM_Result;
        else if (MEMWB_RegWrite && MEMWB_Rd != 5'd0 && MEMWB_Rd == Regt_in)
            w_fwd_b = MEMWB_Data;
    end

    assign w_op_b = EX_in[0] ? Sext_in : w_fwd_b;

    always_comb begin
        w_result = '0;
        case (w_alu_op)
            2'b00: w_result = w_op_a + w_op_b;
            2'b01: w_result = w_op_a - w_op_b;
            2'b11: w_result = w_op_a | w_op_b;
            default: begin
                case (w_funct)
                    6'h20: w_result = w_op_a + w_op_b;
                    6'h22: w_result = w_op_a - w_op_b;
                    6'h24: w_result = w_op_a & w_op_b;
                    6'h25: w_result = w_op_a | w_op_b;
                    6'h2A: w_result = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
                    6'h00: w_result = w_op_b << w_shamt;
                    6'h10: w_result = r_hi;
                    6'h12: w_result = r_lo;
                    default: w_result = '0;
                endcase
            end
        endcase
    end

    assign w_sa    = w_signed_op && w_op_a[XLEN-1];
    assign w_sb    = w_signed_op && w_op_b[XLEN-1];
    assign w_abs_a = w_sa ? -w_op_a : w_op_a;
    assign w_abs_b = w_sb ? -w_op_b : w_op_b;

    // p_hi is the partial product / running remainder, p_lo the multiplier / quotient
    assign w_add     = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_rem_sh  = {r_p_hi, r_p_lo[XLEN-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_mcand};
    assign w_ge      = w_rem_sh >= {1'b0, r_mcand};

    always_comb begin
        if (r_is_div) begin
            w_step_hi = w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            w_step_lo = {r_p_lo[XLEN-2:0], w_ge};
        end else begin
            w_step_hi = w_add[XLEN:1];
            w_step_lo = {w_add[0], r_p_lo[XLEN-1:1]};
        end
    end

    assign w_prod   = {w_step_hi, w_step_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_md_funct;
                if (w_md_funct)
                    w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (r_count == CW'(1))
                    w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_p_hi     <= '0;
            r_p_lo     <= '0;
            r_mcand    <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_md_funct) begin
                        r_count    <= CW'(MD_CYCLES);
                        r_is_div   <= w_funct[1];
                        r_neg_q    <= w_sa ^ w_sb;
                        r_neg_r    <= w_sa;
                        r_div0     <= (w_op_b == '0);
                        r_dividend <= w_op_a;
                        r_p_hi     <= '0;
                        r_p_lo     <= w_funct[1] ? w_abs_a : w_abs_b;
                        r_mcand    <= w_funct[1] ? w_abs_b : w_abs_a;
                    end
                end
                S_BUSY: begin
                    r_count <= r_count - CW'(1);
                    r_p_hi  <= w_step_hi;
                    r_p_lo  <= w_step_lo;
                    if (r_count == CW'(1)) begin
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= w_prod_s;
                        end else if (r_div0) begin
                            r_lo <= '1;
                            r_hi <= r_dividend;
                        end else begin
                            r_lo <= r_neg_q ? -w_step_lo : w_step_lo;
                            r_hi <= r_neg_r ? -w_step_hi : w_step_hi;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // muldiv never writes a GPR, even when not stalled (DONE retire cycle)
    assign stall_out     = w_stall;
    assign WB_out        = w_stall ? 2'b00 : {WB_in[1] & ~w_md_funct, WB_in[0]};
    assign M_out         = w_stall ? 2'b00 : M_in;
    assign ALUResult_out = w_result;
    assign WriteData_out = w_fwd_b;
    assign RegDst_out    = EX_in[3] ? Regd_in : Regt_in;
    assign Zero_out      = (w_result == '0);

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: ALU/forwarding ops, mult/div latency and results,
// and asynchronous reset during a busy divide/multiply.
`timescale 1ns/100ps
module tb_ex_stage;
    localparam int MDC = 32;

    logic        clk, reset_in;
    logic [1:0]  WB_in, M_in;
    logic [3:0]  EX_in;
    logic [31:0] Reg1Data_in, Reg2Data_in, Sext_in;
    logic [4:0]  Regs_in, Regt_in, Regd_in;
    logic        EXMEM_RegWrite, MEMWB_RegWrite;
    logic [4:0]  EXMEM_Rd, MEMWB_Rd;
    logic [31:0] EXMEM_Result, MEMWB_Data;
    logic [1:0]  WB_out, M_out;
    logic [31:0] ALUResult_out, WriteData_out;
    logic [4:0]  RegDst_out;
    logic        Zero_out, stall_out;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    ex_stage dut (
        .clk(clk), .reset_in(reset_in), .WB_in(WB_in), .M_in(M_in), .EX_in(EX_in),
        .Reg1Data_in(Reg1Data_in), .Reg2Data_in(Reg2Data_in), .Sext_in(Sext_in),
        .Regs_in(Regs_in), .Regt_in(Regt_in), .Regd_in(Regd_in),
        .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_Rd(EXMEM_Rd), .EXMEM_Result(EXMEM_Result),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_Rd(MEMWB_Rd), .MEMWB_Data(MEMWB_Data),
        .WB_out(WB_out), .M_out(M_out), .ALUResult_out(ALUResult_out),
        .WriteData_out(WriteData_out), .RegDst_out(RegDst_out), .Zero_out(Zero_out),
        .stall_out(stall_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (EXMEM_RegWrite && EXMEM_Rd != 0 && EXMEM_Rd == r) return EXMEM_Result;
        if (MEMWB_RegWrite && MEMWB_Rd != 0 && MEMWB_Rd == r) return MEMWB_Data;
        return d;
    endfunction

    function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [5:0] f,
                                              input logic [4:0] sh, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return a | b;
            default: case (f)
                6'h20: return a + b;
                6'h22: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h00: return b << sh;
                6'h10: return m_hi;
                6'h12: return m_lo;
                default: return 32'd0;
            endcase
        endcase
    endfunction

    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        case (f)
            6'h18: r = sa * sb;
            6'h19: r = {32'd0, a} * {32'd0, b};
            6'h1A: if (b == 0) r = {a, 32'hFFFF_FFFF};
                   else begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
            6'h1B: if (b == 0) r = {a, 32'hFFFF_FFFF};
                   else r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic alu(input string tag, input logic [1:0] op, input logic alusrc,
                       input logic regdst, input logic [31:0] sext,
                       input logic [31:0] r1, input logic [31:0] r2);
        logic [31:0] e;
        @(posedge clk); #1;
        EX_in = {regdst, op, alusrc}; Sext_in = sext; Reg1Data_in = r1; Reg2Data_in = r2;
        sb_q.push_back(alu_model(op, sext[5:0], sext[10:6], fwd(Regs_in, r1),
                                 alusrc ? sext : fwd(Regt_in, r2)));
        @(negedge clk);
        e = sb_q.pop_front();
        chk(tag, ALUResult_out, e);
        chk({tag, "_zero"}, {31'd0, Zero_out}, {31'd0, e == 0});
        chk({tag, "_rd"}, {27'd0, RegDst_out}, {27'd0, regdst ? Regd_in : Regt_in});
    endtask

    task automatic wait_md(input string tag);
        int n = 0;
        logic bub = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_out) break;
            n++;
            if (WB_out != 2'b00 || M_out != 2'b00) bub = 1'b1;
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(MDC + 1));
        chk({tag, "_bubble"}, {31'd0, bub}, 32'd0);
        chk({tag, "_done_wb"}, {30'd0, WB_out}, 32'd1);
        chk({tag, "_done_m"}, {30'd0, M_out}, 32'd3);
    endtask

    task automatic read_hilo(input string tag);
        @(posedge clk); #1;
        WB_in = 2'b10; M_in = 2'b00; EX_in = 4'b1100; Sext_in = 32'h10;
        @(negedge clk);
        chk({tag, "_hi"}, ALUResult_out, sb_q.pop_front());
        chk({tag, "_hi_nostall"}, {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        Sext_in = 32'h12;
        @(negedge clk);
        chk({tag, "_lo"}, ALUResult_out, sb_q.pop_front());
    endtask

    task automatic drive_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        EX_in = 4'b1100; Sext_in = {26'd0, f}; Reg1Data_in = a; Reg2Data_in = b;
        WB_in = 2'b11; M_in = 2'b11;
    endtask

    task automatic run_md(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        drive_md(f, a, b);
        {m_hi, m_lo} = md_model(f, a, b);
        sb_q.push_back(m_hi);
        sb_q.push_back(m_lo);
        wait_md(tag);
        read_hilo(tag);
    endtask

    initial begin
        reset_in = 1'b0;
        WB_in = 2'b10; M_in = 2'b00; EX_in = 4'b1100;
        Reg1Data_in = '0; Reg2Data_in = '0; Sext_in = 32'h10;
        Regs_in = 5'd1; Regt_in = 5'd2; Regd_in = 5'd9;
        EXMEM_RegWrite = 1'b0; EXMEM_Rd = '0; EXMEM_Result = '0;
        MEMWB_RegWrite = 1'b0; MEMWB_Rd = '0; MEMWB_Data = '0;
        #3;
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_hi", ALUResult_out, 32'd0);
        Sext_in = 32'h18;
        #1;
        chk("rst_md_stall", {31'd0, stall_out}, 32'd1);
        Sext_in = 32'h20;
        #4;
        reset_in = 1'b1;

        alu("add", 2'b10, 1'b0, 1'b1, 32'h20, 32'd5, 32'd7);
        alu("sub", 2'b10, 1'b0, 1'b1, 32'h22, 32'd5, 32'd7);
        chk("wb_pass", {30'd0, WB_out}, 32'd2);
        alu("and", 2'b10, 1'b0, 1'b1, 32'h24, 32'h0000_F0F0, 32'h0000_FF00);
        alu("or", 2'b10, 1'b0, 1'b1, 32'h25, 32'h0000_F0F0, 32'h0000_FF00);
        alu("slt_t", 2'b10, 1'b0, 1'b1, 32'h2A, 32'hFFFF_FFFF, 32'd1);
        alu("slt_f", 2'b10, 1'b0, 1'b1, 32'h2A, 32'd1, 32'hFFFF_FFFF);
        alu("sll", 2'b10, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 32'd1);
        alu("unlisted", 2'b10, 1'b0, 1'b1, 32'h3F, 32'd5, 32'd7);
        alu("ori", 2'b11, 1'b1, 1'b0, 32'h0F, 32'hF0, 32'd0);
        alu("beq_sub", 2'b01, 1'b0, 1'b0, 32'd0, 32'd9, 32'd9);

        Regs_in = 5'd3;
        EXMEM_RegWrite = 1'b1; EXMEM_Rd = 5'd3; EXMEM_Result = 32'h10;
        MEMWB_RegWrite = 1'b1; MEMWB_Rd = 5'd3; MEMWB_Data = 32'h20;
        alu("dhaz", 2'b00, 1'b1, 1'b0, 32'd1, 32'h55, 32'd0);
        Regs_in = 5'd0; EXMEM_Rd = 5'd0; MEMWB_Rd = 5'd0;
        alu("r0_nofwd", 2'b00, 1'b1, 1'b0, 32'd1, 32'd5, 32'd0);
        EXMEM_RegWrite = 1'b0; EXMEM_Rd = 5'd2; EXMEM_Result = 32'h30;
        MEMWB_Rd = 5'd2; MEMWB_Data = 32'h77; Regs_in = 5'd1;
        alu("memwb_rt", 2'b10, 1'b0, 1'b1, 32'h20, 32'd1, 32'h99);
        chk("memwb_wd", WriteData_out, fwd(Regt_in, Reg2Data_in));
        EXMEM_RegWrite = 1'b1;
        alu("exmem_rt", 2'b10, 1'b0, 1'b1, 32'h20, 32'd1, 32'h99);
        chk("exmem_wd", WriteData_out, fwd(Regt_in, Reg2Data_in));
        EXMEM_RegWrite = 1'b0; MEMWB_RegWrite = 1'b0;

        run_md("mult", 6'h18, 32'hFFFF_FFFE, 32'd3);
        run_md("multu", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md("div", 6'h1A, 32'hFFFF_FFF9, 32'd2);
        run_md("divu0", 6'h1B, 32'd7, 32'd0);
        run_md("div0s", 6'h1A, 32'hFFFF_FFFB, 32'd0);
        run_md("divu", 6'h1B, 32'd100, 32'd7);
        run_md("divmin", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("div_ps", 6'h1A, 32'd7, 32'hFFFF_FFFE);

        // abort a multiply mid-flight with count at 10
        @(posedge clk); #1;
        drive_md(6'h18, 32'd6, 32'd7);
        @(negedge clk);
        repeat (23) @(posedge clk);
        #2;
        reset_in = 1'b0;
        m_hi = '0; m_lo = '0;
        #1;
        EX_in = 4'b1100; Sext_in = 32'h10;
        sb_q.push_back(m_hi);
        #1;
        chk("rstmid_hi", ALUResult_out, sb_q.pop_front());
        chk("rstmid_nostall", {31'd0, stall_out}, 32'd0);
        Sext_in = 32'h12;
        sb_q.push_back(m_lo);
        #1;
        chk("rstmid_lo", ALUResult_out, sb_q.pop_front());
        Sext_in = 32'h18;
        #1;
        chk("rstmid_md_stall", {31'd0, stall_out}, 32'd1);
        reset_in = 1'b1;
        {m_hi, m_lo} = md_model(6'h18, 32'd6, 32'd7);
        sb_q.push_back(m_hi);
        sb_q.push_back(m_lo);
        wait_md("reissue");
        read_hilo("reissue");

        WB_in = 2'b11; M_in = 2'b10; Regt_in = 5'd5;
        alu("lw", 2'b00, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h100, 32'd0);
        chk("lw_m", {30'd0, M_out}, 32'd2);
        chk("lw_wb", {30'd0, WB_out}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Consumes the ID/EX pipeline register outputs and produces the operands and control for the EX/MEM register.
- Contains the forwarding muxes, ALU control decode, the 32-bit ALU, destination-register select, and an iterative multiply/divide unit with HI/LO registers.
- Raises a pipeline stall while a multi-cycle op runs.

Parameters:
- XLEN, 32, datapath width
- MD_CYCLES, 32, iteration cycles per mult/div

Ports:
- clk  input  1  clock
- reset_in  input  1  asynchronous active-low reset
- WB_in  input  2  {RegWrite, MemtoReg} from ID/EX
- M_in  input  2  {MemRead, MemWrite} from ID/EX
- EX_in  input  4  {RegDst, ALUOp[1:0], ALUSrc}
- Reg1Data_in, Reg2Data_in  input  32  rs/rt read data
- Sext_in  input  32  sign-extended immediate; funct=[5:0], shamt=[10:6]
- Regs_in, Regt_in, Regd_in  input  5  rs/rt/rd numbers
- EXMEM_RegWrite  input  1  forwarding source control
- EXMEM_Rd  input  5  forwarding source register
- EXMEM_Result  input  32  forwarding source data
- MEMWB_RegWrite  input  1  forwarding source control
- MEMWB_Rd  input  5  forwarding source register
- MEMWB_Data  input  32  forwarding source data
- WB_out  output  2  to EX/MEM
- M_out  output  2  to EX/MEM
- ALUResult_out  output  32  ALU / mfhi / mflo result
- WriteData_out  output  32  forwarded rt value (store data)
- RegDst_out  output  5  destination register
- Zero_out  output  1  ALUResult_out == 0
- stall_out  output  1  hold PC, IF/ID, ID/EX this cycle

Behaviour:
- Forwarding, operand A from rs:
  - EXMEM_RegWrite && EXMEM_Rd!=0 && EXMEM_Rd==Regs_in -> EXMEM_Result
  - else MEMWB_RegWrite && MEMWB_Rd!=0 && MEMWB_Rd==Regs_in -> MEMWB_Data
  - else Reg1Data_in
  - EX/MEM wins when both match.
- Forwarding, rt value: same priority applied to Regt_in. The forwarded rt value drives WriteData_out.
- Operand B: ALUSrc ? Sext_in : forwarded rt.
- ALUOp decode:
  - 00 = add
  - 01 = sub
  - 11 = or
  - 10 = R-type by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x00 sll (B << shamt), 0x10 mfhi, 0x12 mflo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
  - Unlisted funct -> result 0.
- Arithmetic wraps modulo 2^32; no overflow trap.
- RegDst_out = RegDst ? Regd_in : Regt_in.
- ALU path is combinational, same cycle as the ID/EX outputs.
- Mult/div FSM, states IDLE, BUSY, DONE:
  - IDLE: a muldiv funct under ALUOp=10 asserts stall_out combinationally. At the clock edge, latch the operand magnitudes and signs, set count=MD_CYCLES, go to BUSY.
  - BUSY: stall_out=1. One iteration per cycle: shift-add for mult, restoring divide for div. count decrements. When count reaches 0, write HI/LO (sign-corrected for signed ops) and go to DONE.
  - DONE: stall_out=0 and the instruction retires. Go to IDLE at the next edge.
  - Total stall is MD_CYCLES+1 cycles: issue cycle plus 32.
- Results:
  - mult/multu: {HI,LO} = 64-bit product.
  - div/divu: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO=0xFFFFFFFF, HI=dividend, same latency.
- While stall_out=1: WB_out and M_out are forced to 0 (bubble). Otherwise they pass WB_in/M_in.
- mult/div never write a GPR. Decode delivers RegWrite=0 for them, and this block also forces WB_out[1]=0 on every muldiv funct.
- mfhi/mflo read HI/LO as updated at the DONE transition. A following instruction sees the new value with no extra stall.
- Reset (reset_in=0, asynchronous): FSM->IDLE, count=0, HI=LO=0.
  - Combinational outputs follow their inputs; stall_out=0 unless a muldiv op is present.
  - Reset asserted mid-BUSY aborts the op; HI/LO become 0.

Test Plan:
- R-type add 5+7, then sub 5-7, no hazards -> ALUResult 12, then 0xFFFFFFFE; Zero_out=0; RegDst_out=Regd_in.
- Double hazard: EXMEM_Rd=MEMWB_Rd=Regs_in=3, EXMEM_Result=0x10, MEMWB_Data=0x20, add with B=1 -> result 0x11. Repeat with Regs_in=0 -> forwarding ignored.
- mult 0xFFFFFFFE x 3 (signed) -> stall_out high 33 cycles, WB_out/M_out=0 throughout; next mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> LO=0xFFFFFFFF, HI=7, 33-cycle stall.
- reset_in pulsed low at BUSY count=10, no clock edge -> FSM IDLE, HI=LO=0 immediately; after release the op re-issues from IDLE.
- lw with ALUSrc=1, Reg1=0x100, Sext=0xFFFFFFFC -> ALUResult 0xFC, RegDst_out=Regt_in, M_out passes {1,0}.
